prime_detector_seq: RTL and testbench

//  Sequential, parametrised successor to the combinational 3-bit prime detector.

---
 rtl/prime_detector_if.sv | 28 ++
 rtl/prime_detector_seq.sv | 156 +++++++++++++++
 tb/tb_prime_detector_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/prime_detector_if.sv
// Handshake bundle for prime_detector_seq.
// The operand channel and the result channel each use a valid/ready pair.
//   in_valid / in_ready / in_data         operand n, WIDTH-bit unsigned
//   out_valid / out_ready                 result transfer
//   out_prime / out_factor                1 = prime; smallest factor >1 if composite, else 0
// The master modport belongs to the producer/consumer side.
// The slave modport belongs to the detector.
interface prime_detector_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_prime;
  logic [WIDTH-1:0] out_factor;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_prime, out_factor
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_prime, out_factor
  );
endinterface

// File: rtl/prime_detector_seq.sv
// Sequential prime detector using trial division.
// One operand is accepted over the bus input handshake. Divisors d = 2..floor(sqrt(n))
// are tried in turn. A single restoring divider, producing one quotient bit per cycle,
// is shared by all divisors. The result comes back over the bus output handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; it aborts any operation in flight
//   bus    prime_detector_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_prime/out_factor)
// Parameter: WIDTH operand width, legal range 4..32.
// Build option: when PRIME_FASTPATH_EN is defined, the following cases resolve in the
// first CHECK cycle:
//   - operands below 8
//   - even operands (result: composite, factor 2)
// All other operands are tried against odd divisors only. Results are the same in both
// builds; only the latency differs.
module prime_detector_seq #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  prime_detector_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PRIME_FASTPATH_EN
  localparam logic [WIDTH-1:0] D_START = WIDTH'(3);
  localparam logic [WIDTH-1:0] D_STEP  = WIDTH'(2);
`else
  localparam logic [WIDTH-1:0] D_START = WIDTH'(2);
  localparam logic [WIDTH-1:0] D_STEP  = WIDTH'(1);
`endif

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] n;        // latched operand
  logic [WIDTH-1:0] d;        // current trial divisor
  logic [WIDTH-1:0] quot;     // dividend shifts out of the top; quotient bits shift in at the bottom
  logic [WIDTH-1:0] rem;      // partial remainder; always < d
  logic [CNT_W-1:0] bit_cnt;  // quotient bit index within one division
  logic             out_valid_q;
  logic             out_prime_q;
  logic [WIDTH-1:0] out_factor_q;

  // Restoring-division step. The trial value needs one extra bit because rem can be up to d-1.
  logic [WIDTH:0]     trial;
  logic               trial_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] d_sq;

  // NOTE: every variable driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    trial    = {rem, quot[WIDTH-1]};
    trial_ge = (trial >= {1'b0, d});
    // When trial >= d the difference is < d, so a WIDTH-bit subtraction is exact.
    rem_next = trial_ge ? (trial[WIDTH-1:0] - d) : trial[WIDTH-1:0];
    // The square is formed at double width so it cannot overflow.
    d_sq     = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the reset clears every register, including the datapath registers, so an aborted run leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n            <= '0;
      d            <= '0;
      quot         <= '0;
      rem          <= '0;
      bit_cnt      <= '0;
      out_valid_q  <= 1'b0;
      out_prime_q  <= 1'b0;
      out_factor_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            n     <= bus.in_data;
            d     <= D_START;
            state <= CHECK;
          end
        end

        CHECK: begin
`ifdef PRIME_FASTPATH_EN
          // Fast cases resolve here rather than at accept.
          // This keeps their latency equal to that of the n<2 path.
          if (n < WIDTH'(8)) begin
            out_prime_q  <= (n[1] & ~n[2]) | (n[0] & n[2]);
            out_factor_q <= (n == WIDTH'(4) || n == WIDTH'(6)) ? WIDTH'(2) : '0;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else if (!n[0]) begin
            out_prime_q  <= 1'b0;
            out_factor_q <= WIDTH'(2);
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else
`endif
          if (n < WIDTH'(2)) begin
            out_prime_q  <= 1'b0;
            out_factor_q <= '0;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else if (d_sq > {{WIDTH{1'b0}}, n}) begin
            // No divisor up to floor(sqrt(n)) divided n.
            out_prime_q  <= 1'b1;
            out_factor_q <= '0;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else begin
            quot    <= n;
            rem     <= '0;
            bit_cnt <= '0;
            state   <= DIV;
          end
        end

        DIV: begin
          quot    <= {quot[WIDTH-2:0], trial_ge};
          rem     <= rem_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_LAST) begin
            if (rem_next == '0) begin
              out_prime_q  <= 1'b0;
              out_factor_q <= d;
              out_valid_q  <= 1'b1;
              state        <= DONE;
            end else begin
              d     <= d + D_STEP;
              state <= CHECK;
            end
          end
        end

        DONE: begin
          // The result is held until it transfers. There is no bypass into a new accept.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_prime  = out_prime_q;
  assign bus.out_factor = out_factor_q;

endmodule

// File: tb/tb_prime_detector_seq.sv
// Self-checking bench for prime_detector_seq (WIDTH=8).
// Build it with and without PRIME_FASTPATH_EN.
// A reference model computes primality, the smallest factor and the expected latency
// directly with modulo arithmetic. A negedge compare process checks every valid result
// cycle against that model. Directed scenarios also pin literal values.
module tb_prime_detector_seq;
  localparam int W      = 8;
  localparam int BUDGET = 1000;

`ifdef PRIME_FASTPATH_EN
  localparam int LAT_251 = 64;
  localparam int LAT_221 = 54;
`else
  localparam int LAT_251 = 127;
  localparam int LAT_221 = 108;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic exp_active = 1'b0;
  logic exp_prime  = 1'b0;
  int   exp_factor = 0;
  int   exp_lat    = 0;

  prime_detector_if #(.WIDTH(W)) bus ();

  prime_detector_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model derived from the arithmetic definition of primality.
  function automatic void model(input int n, output logic p, output int f, output int lat);
    int t;
    int d0;
    int step;
`ifdef PRIME_FASTPATH_EN
    d0 = 3; step = 2;
`else
    d0 = 2; step = 1;
`endif
    t = 0; p = 1'b0; f = 0; lat = 1;
    if (n < 2) return;
`ifdef PRIME_FASTPATH_EN
    if (n < 8 || n % 2 == 0) begin
      p = (n == 2 || n == 3 || n == 5 || n == 7);
      f = (n == 4 || n == 6 || n >= 8) ? 2 : 0;
      return;
    end
`endif
    p = 1'b1;
    for (int d = d0; d * d <= n; d += step) begin
      t++;
      if (n % d == 0) begin
        p = 1'b0;
        f = d;
        break;
      end
    end
    lat = p ? 1 + t * (W + 1) : t * (W + 1);
  endfunction

  // Compare process: checks every cycle in which a result is presented.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      check("no_spurious_result", exp_active, 1);
      if (exp_active) begin
        check("out_prime", bus.out_prime, exp_prime);
        check("out_factor", bus.out_factor, exp_factor);
        check("in_ready_low_in_done", bus.in_ready, 0);
      end
    end
  end

  // Runs one operand through the block and returns the measured latency and result.
  // The result is held for 'hold' cycles before out_ready is raised.
  task automatic run_op(input int n, input int hold, output int lat, output logic p, output int f);
    int waited;
    int acc;
    lat = 0; p = 1'b0; f = 0; waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", bus.in_ready, 1);
    if (!bus.in_ready) return;
    model(n, exp_prime, exp_factor, exp_lat);
    bus.out_ready = (hold == 0);
    bus.in_data   = W'(n);
    bus.in_valid  = 1'b1;
    exp_active    = 1'b1;
    @(negedge clk);
    acc          = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    waited = 0;
    while (!bus.out_valid && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("result_valid", bus.out_valid, 1);
    if (!bus.out_valid) begin
      exp_active = 1'b0;
      return;
    end
    lat = cyc - acc;
    p   = bus.out_prime;
    f   = bus.out_factor;
    check("latency", lat, exp_lat);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_active = 1'b0;
    check("valid_low_after_xfer", bus.out_valid, 0);
    check("ready_high_after_xfer", bus.in_ready, 1);
  endtask

  initial begin
    automatic logic [7:0] prime_tab  = 8'b1010_1100;  // bit n set for n = 2,3,5,7
    automatic int         factor_tab [8] = '{0, 0, 0, 0, 2, 0, 2, 0};
    int   lat;
    int   f;
    logic p;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1. Reset, then release.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_prime", bus.out_prime, 0);
    check("reset_out_factor", bus.out_factor, 0);
    check("reset_in_ready", bus.in_ready, 1);

    // 2. Sweep 0..7 with out_ready high.
    for (int n = 0; n < 8; n++) begin
      run_op(n, 0, lat, p, f);
      check($sformatf("sweep_prime_%0d", n), p, prime_tab[n]);
      check($sformatf("sweep_factor_%0d", n), f, factor_tab[n]);
`ifdef PRIME_FASTPATH_EN
      check($sformatf("sweep_lat_%0d", n), lat, 1);
`endif
    end

    // 3. Largest prime below 256.
    run_op(251, 0, lat, p, f);
    check("p251_prime", p, 1);
    check("p251_factor", f, 0);
    check("p251_latency", lat, LAT_251);

    // 4. 13*17.
    run_op(221, 0, lat, p, f);
    check("c221_prime", p, 0);
    check("c221_factor", f, 13);
    check("c221_latency", lat, LAT_221);

    // Boundary operands: all-ones input, and a perfect square where d*d == n.
    run_op(255, 0, lat, p, f);
    check("c255_factor", f, 3);
    run_op(169, 0, lat, p, f);
    check("c169_factor", f, 13);

    // 5. Result held under back-pressure.
    run_op(9, 20, lat, p, f);
    check("c9_prime", p, 0);
    check("c9_factor", f, 3);

    // 6. Abort during division of 251.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_data   = W'(251);
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_busy", bus.in_ready, 0);
    #2;
    exp_active = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(200, 0, lat, p, f);
    check("c200_prime", p, 0);
    check("c200_factor", f, 2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
